// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the instruction encoder: opcodes, one-hot type
// bit positions and rejection codes.
package riscv_pkg;
  localparam int XLEN              = 32;
  localparam int REG_FILE_DEPTH    = 32;
  localparam int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH);

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // bit positions inside types = {R,I,L,S,J,B,U}
  localparam int T_R = 6;
  localparam int T_I = 5;
  localparam int T_L = 4;
  localparam int T_S = 3;
  localparam int T_J = 2;
  localparam int T_B = 1;
  localparam int T_U = 0;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_TYPE   = 3'd1,
    ERR_BAD_OPCODE = 3'd2,
    ERR_MISALIGNED = 3'd3,
    ERR_RANGE      = 3'd4
  } err_code_e;
endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with legality checks; the first failing
// check determines the reported code.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [6:0]                   types,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [REG_FILE_ADDR_LEN-1:0] rd,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
  input  logic [XLEN-1:0]              imm,
  output logic [XLEN-1:0]              instr,
  output logic                         err,
  output logic [2:0]                   err_code
);
  logic      one_hot, is_jal, opc_ok, misaligned, range_err;
  logic      fits12, fits13, fits21;
  err_code_e code;

  always_comb begin
    one_hot = (types != '0) && ((types & (types - 7'd1)) == '0);
    is_jal  = types[T_J] && (opcode == JAL);
    opc_ok  = (types[T_R] && opcode == OP)     || (types[T_I] && opcode == OP_IMM) ||
              (types[T_L] && opcode == LOAD)   || (types[T_S] && opcode == STORE)  ||
              (types[T_B] && opcode == BRANCH) ||
              (types[T_J] && (opcode == JAL || opcode == JALR)) ||
              (types[T_U] && (opcode == LUI || opcode == AUIPC));
    misaligned = (types[T_B] || is_jal) && imm[0];

    // an immediate fits N bits when everything from bit N-1 upward is one sign
    fits12 = (&imm[31:11]) || !(|imm[31:11]);
    fits13 = (&imm[31:12]) || !(|imm[31:12]);
    fits21 = (&imm[31:20]) || !(|imm[31:20]);

    range_err = 1'b0;
    if (types[T_B])                                            range_err = !fits13;
    else if (is_jal)                                           range_err = !fits21;
    else if (types[T_U])                                       range_err = |imm[11:0];
    else if (types[T_I] || types[T_L] || types[T_S] || types[T_J]) range_err = !fits12;

    code = ERR_NONE;
    if (!one_hot)        code = ERR_BAD_TYPE;
    else if (!opc_ok)    code = ERR_BAD_OPCODE;
    else if (misaligned) code = ERR_MISALIGNED;
    else if (range_err)  code = ERR_RANGE;
    err      = (code != ERR_NONE);
    err_code = code;

    // I, L and JALR share the I-format layout, handled by the final branch
    if (types[T_R])
      instr = {funct7, rs2, rs1, funct3, rd, opcode};
    else if (types[T_S])
      instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
    else if (types[T_B])
      instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    else if (is_jal)
      instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    else if (types[T_U])
      instr = {imm[31:12], rd, opcode};
    else
      instr = {imm[11:0], rs1, funct3, rd, opcode};
  end
endmodule

// File: rtl/instruction_encoder.sv
// Accepts decoded field bundles, packs them into RV32I words and queues them
// with their word address in a 2-entry FIFO; rejected bundles raise an error.
module instruction_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [6:0]                   types,
  input  logic [6:0]                   opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [REG_FILE_ADDR_LEN-1:0] rd,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
  input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
  input  logic [XLEN-1:0]              imm,
  input  logic                         addr_load,
  input  logic [ADDR_WIDTH-1:0]        addr_init,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_instr,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         err_valid,
  output logic [2:0]                   err_code
);
  logic [XLEN-1:0]       pk_instr;
  logic                  pk_err;
  logic [2:0]            pk_code;

  logic [XLEN-1:0]       instr_q [2];
  logic [ADDR_WIDTH-1:0] waddr_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_addr;
  logic                  err_valid_q;
  logic [2:0]            err_code_q;
  logic                  accept, push, pop;

  instr_pack u_pack (
    .types    (types),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .instr    (pk_instr),
    .err      (pk_err),
    .err_code (pk_code)
  );

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_instr = instr_q[rd_ptr_q];
  assign out_addr  = waddr_q[rd_ptr_q];
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && !pk_err;
  assign pop    = out_valid && out_ready;

  // a load in the same cycle as an accept addresses that very word
  assign base_addr = addr_load ? addr_init : addr_q;
  assign addr_d    = push ? base_addr + ADDR_WIDTH'(1) : base_addr;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        waddr_q[i] <= '0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      addr_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= pk_instr;
        waddr_q[wr_ptr_q] <= base_addr;
        wr_ptr_q          <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_valid_q <= accept && pk_err;
      if (accept && pk_err) err_code_q <= pk_code;
    end
  end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs decoded RISC-V field bundles (rd/rs1/rs2/opcode/funct3/funct7, one-hot type, immediate) back into 32-bit RV32I instruction words. Each accepted bundle is range-checked and queued in a 2-entry output FIFO tagged with a word address. This is the inverse of `instruction_decoder`. It feeds the program-loader path into instruction memory and serves as a golden-stimulus source for decoder benches.

## Interface
- XLEN, 32, datapath and instruction width
- REG_FILE_DEPTH, 32, register count
- REG_FILE_ADDR_LEN, $clog2(REG_FILE_DEPTH), register index width
- ADDR_WIDTH, 10, instruction-memory word address width

- clk  in  1  clock; only clock
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1 / 1  request handshake
- types  in  7  one-hot {R,I,L,S,J,B,U}, same bit order as the decoder's `types`
- opcode, funct3, funct7  in  7/3/7  raw fields
- rd, rs1, rs2  in  REG_FILE_ADDR_LEN  register indices
- imm  in  XLEN  sign-extended byte-offset immediate (U: full value with low 12 bits zero)
- addr_load, addr_init  in  1, ADDR_WIDTH  load the address counter
- out_valid / out_ready  out / in  1 / 1  output handshake
- out_instr  out  XLEN  encoded word
- out_addr  out  ADDR_WIDTH  word address of out_instr
- err_valid  out  1  one-cycle pulse per rejected request
- err_code  out  3  code of the last rejection; held until the next rejection

## Operation
- Accept on in_valid && in_ready. in_ready = (fifo_count != 2), driven from the registered count.
- Encoding by type:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I, L, and J with opcode 1100111 (JALR): {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - J with opcode 1101111 (JAL): {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - U: {imm[31:12],rd,opcode}
- Checks, first match wins:
  - 1, BAD_TYPE: types not one-hot.
  - 2, BAD_OPCODE: opcode not legal for the type. R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, J 1101111/1100111, U 0110111/0010111.
  - 3, MISALIGNED: B or JAL with imm[0]=1.
  - 4, RANGE:
    - I/L/JALR/S: imm is not a 12-bit sign-extension.
    - B: imm is not a 13-bit sign-extension.
    - JAL: imm is not a 21-bit sign-extension.
    - U: imm[11:0]!=0.
- A rejected request is still consumed (handshake completes). It is not enqueued, the address does not advance, err_valid pulses and err_code updates.
- Address counter:
  - Reset value 0.
  - addr_load sets it to addr_init. When addr_load and an accept occur in the same cycle, the load applies first: the accepted word gets addr_init and the counter becomes addr_init+1.
  - Increments by 1 per legal accept and wraps from 2^ADDR_WIDTH-1 to 0.
- FIFO:
  - 2 entries of {instr, addr}; strict order.
  - out_* show the head entry; a pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle leave the count unchanged.

## Timing
- Latency: a request accepted at edge N has out_valid=1 after edge N, provided the FIFO was empty.
- Throughput: 1 word/cycle while out_ready=1.
- out_* are stable while out_valid && !out_ready.
- Reset values (async assert, sync release): fifo_count 0, in_ready 1, out_valid 0, out_instr 0, out_addr 0, counter 0, err_valid 0, err_code 0.
- Reset mid-operation drops FIFO contents and any pending error pulse; no partial handshake survives.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC)
  - type-bit indices
  - error-code constants
- Sub-module `instr_pack`: purely combinational field packer plus checker, outputs {instr, err, err_code}.
- Top level holds the FIFO, address counter and error register.

## Test plan
- R type (opcode 0110011), rd=3, rs1=1, rs2=2, funct3=0, funct7=0, after reset -> out_instr 0x002081B3, out_addr 0, out_valid one cycle after accept.
- I type (opcode 0010011), rd=1, rs1=0, imm=0xFFFFFFFF; then B type (opcode 1100011), imm=0xFFFFFFFC; then JAL, rd=1, imm=8 -> 0xFFF00093, 0xFE000EE3, 0x008000EF at addresses 0, 1, 2.
- Errors, one at a time:
  - B with imm=3 -> err_valid pulse, err_code 3, nothing enqueued, next legal word keeps the unchanged address.
  - types=7'b1100000 -> err_code 1.
  - U with imm=0x00000123 -> err_code 4.
- Backpressure: hold out_ready=0 and offer 3 legal words -> in_ready drops after 2 accepts. Release out_ready -> all 3 emerge in order with addresses 0, 1, 2 and no loss or duplication.
- addr_load=1, addr_init=0x3FF, same cycle as an accept, then a second word -> addresses 0x3FF then 0x000.
- Assert rst_n=0 with 2 words queued -> out_valid=0 and in_ready=1 immediately. After release, the next word gets address 0.
